// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - requester, pipeline and expander signal bundle for the key schedule controller
interface aes_key_sched_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 3
);
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*128-1:0] req_key;
    logic [NUM_REQ-1:0]     ack;
    logic                   ack_err;
    logic                   pipe_hold;
    logic                   pipe_empty;
    logic                   exp_key_valid;
    logic [127:0]           exp_key_in;
    logic                   exp_keys_valid;
    logic                   exp_busy;
    logic [IDW-1:0]         key_owner;
    logic                   key_installed;

    // Environment side: requesters, cipher pipeline and key expander
    modport master (
        output req, req_key, pipe_empty, exp_keys_valid, exp_busy,
        input  ack, ack_err, pipe_hold, exp_key_valid, exp_key_in, key_owner, key_installed
    );

    // Controller side
    modport slave (
        input  req, req_key, pipe_empty, exp_keys_valid, exp_busy,
        output ack, ack_err, pipe_hold, exp_key_valid, exp_key_in, key_owner, key_installed
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - round-robin shared AES-128 key expander controller with one-entry key cache
module aes_key_sched_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int IDW     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_key_sched_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {IDLE, ARB, DRAIN, LOAD, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]       gnt_id_q, gnt_id_d;
    logic [127:0]         gnt_key_q, gnt_key_d;
    logic [IDW-1:0]       key_owner_q, key_owner_d;
    logic [127:0]         exp_key_in_q, exp_key_in_d;
    logic                 key_installed_q, key_installed_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 ack_err_q, ack_err_d;
    logic                 pipe_hold_q, pipe_hold_d;
    logic                 exp_key_valid_q, exp_key_valid_d;

    logic                 hi_found, lo_found, arb_found;
    logic [IDW-1:0]       hi_id, lo_id, arb_id;
    logic [127:0]         hi_key, lo_key, arb_key;

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest below it (wrap)
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_key   = '0;
        lo_key   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(i);
                    hi_key   = bus.req_key[128*i +: 128];
                end else begin
                    lo_found = 1'b1;
                    lo_id    = IDW'(i);
                    lo_key   = bus.req_key[128*i +: 128];
                end
            end
        end
        arb_found = hi_found | lo_found;
        arb_id    = hi_found ? hi_id  : lo_id;
        arb_key   = hi_found ? hi_key : lo_key;
    end

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        gnt_id_d        = gnt_id_q;
        gnt_key_d       = gnt_key_q;
        key_owner_d     = key_owner_q;
        exp_key_in_d    = exp_key_in_q;
        key_installed_d = key_installed_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) state_d = ARB;
            end
            ARB: begin
                if (!arb_found) begin
                    state_d = IDLE;
                end else begin
                    gnt_id_d  = arb_id;
                    gnt_key_d = arb_key;
                    // Cache hit: the installed round keys already belong to this key
                    if (key_installed_q && (arb_key == exp_key_in_q)) state_d = DONE;
                    else                                              state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.pipe_empty && !bus.exp_busy) begin
                    // Key and load pulse are presented together in the LOAD cycle
                    state_d         = LOAD;
                    exp_key_in_d    = gnt_key_q;
                    key_installed_d = 1'b0;
                    cnt_d           = '0;
                end
            end
            LOAD: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q != CW'(TIMEOUT - 1)) cnt_d = cnt_q + 1'b1;
                // Keys arriving on the timeout cycle still count as success
                if (bus.exp_keys_valid) begin
                    key_installed_d = 1'b1;
                    key_owner_d     = gnt_id_q;
                    state_d         = DONE;
                end else if (cnt_d == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                err_d    = 1'b0;
                rr_ptr_d = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        pipe_hold_d     = (state_d == DRAIN) || (state_d == LOAD) || (state_d == WAIT);
        exp_key_valid_d = (state_d == LOAD);
        ack_err_d       = (state_d == DONE) && err_d;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_d[i] = (state_d == DONE) && (gnt_id_d == IDW'(i));
        end
    end

    // State and output registers, synchronous reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            gnt_id_q        <= '0;
            gnt_key_q       <= '0;
            key_owner_q     <= '0;
            exp_key_in_q    <= '0;
            key_installed_q <= 1'b0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            ack_q           <= '0;
            ack_err_q       <= 1'b0;
            pipe_hold_q     <= 1'b0;
            exp_key_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_id_q        <= gnt_id_d;
            gnt_key_q       <= gnt_key_d;
            key_owner_q     <= key_owner_d;
            exp_key_in_q    <= exp_key_in_d;
            key_installed_q <= key_installed_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            ack_q           <= ack_d;
            ack_err_q       <= ack_err_d;
            pipe_hold_q     <= pipe_hold_d;
            exp_key_valid_q <= exp_key_valid_d;
        end
    end

    assign bus.ack           = ack_q;
    assign bus.ack_err       = ack_err_q;
    assign bus.pipe_hold     = pipe_hold_q;
    assign bus.exp_key_valid = exp_key_valid_q;
    assign bus.exp_key_in    = exp_key_in_q;
    assign bus.key_owner     = key_owner_q;
    assign bus.key_installed = key_installed_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - scoreboard bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 3;
    localparam int EXP_LAT = 42;

    localparam logic [127:0] K0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] K1 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] K2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] K3 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    localparam logic [127:0] K4 = 128'h13579bdf_2468ace0_fdb97531_0eca8642;
    localparam logic [127:0] K5 = 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
    localparam logic [127:0] K6 = 128'h01010101_02020202_04040404_08080808;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_sched_ctrl_if #(.NUM_REQ(NUM_REQ), .IDW(IDW)) bus ();

    aes_key_sched_ctrl #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int   id;
        logic err;
        logic inst;
        int   owner;
        int   hold;
        int   lat;
    } exp_ack_t;

    exp_ack_t     sb_q[$];
    logic [127:0] key_q[$];

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int load_cyc = 0;
    int load_cnt = 0;
    int hold_cnt = 0;
    int exp_cnt  = 0;
    bit exp_never = 1'b0;
    int req_cyc[NUM_REQ];
    int keep[NUM_REQ];

    // A requester may only drop req in the cycle its ack is shown
    logic [NUM_REQ-1:0] req_prev = '0;
    always @(posedge clk) begin
        if (!rst) begin
            assert ((req_prev & ~bus.req & ~bus.ack) == '0)
                else $error("FAIL req dropped before ack: %b", req_prev & ~bus.req);
        end
        req_prev <= bus.req;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ack(input int id, input logic err, input logic inst,
                            input int owner, input int hold, input int lat);
        exp_ack_t e;
        e.id = id; e.err = err; e.inst = inst; e.owner = owner; e.hold = hold; e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic raise(input int i, input logic [127:0] k);
        bus.req_key[128*i +: 128] = k;
        bus.req[i] = 1'b1;
        req_cyc[i] = cyc;
    endtask

    // One clock: expander model, monitors and requester release, all at the falling edge
    task automatic tick();
        exp_ack_t           e;
        logic [NUM_REQ-1:0] m;
        @(negedge clk);
        cyc++;
        bus.exp_keys_valid = 1'b0;
        if (exp_cnt > 0) begin
            exp_cnt--;
            if (exp_cnt == 0) begin
                bus.exp_busy = 1'b0;
                if (!exp_never) bus.exp_keys_valid = 1'b1;
            end
        end
        if (bus.exp_key_valid === 1'b1) begin
            exp_cnt      = EXP_LAT;
            bus.exp_busy = 1'b1;
            load_cyc     = cyc;
            load_cnt++;
            check_eq("pipe_hold at load", bus.pipe_hold, 1);
            if (key_q.size() == 0) check_eq("spurious load", bus.exp_key_valid, 0);
            else                   check_eq("load key", bus.exp_key_in, key_q.pop_front());
        end
        if (bus.pipe_hold === 1'b1) hold_cnt++;
        if (bus.ack !== '0) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious ack", bus.ack, 0);
            end else begin
                e = sb_q.pop_front();
                m = '0;
                m[e.id] = 1'b1;
                check_eq("ack id", bus.ack, m);
                check_eq("ack_err", bus.ack_err, e.err);
                check_eq("key_installed", bus.key_installed, e.inst);
                check_eq("key_owner", bus.key_owner, e.owner);
                check_eq("pipe_hold at ack", bus.pipe_hold, 0);
                if (e.hold >= 0) check_eq("hold cycles", hold_cnt, e.hold);
                if (e.lat >= 0)  check_eq("ack latency", cyc - req_cyc[e.id], e.lat);
                if (e.err)       check_eq("timeout distance", cyc - load_cyc, TIMEOUT);
            end
            hold_cnt = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.ack[i]) begin
                    if (keep[i] > 0) begin
                        keep[i]--;
                        req_cyc[i] = cyc;
                    end else begin
                        bus.req[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int n = 0; n < budget && (sb_q.size() + key_q.size()) > 0; n++) tick();
        check_eq("drain within budget", sb_q.size() + key_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " ack"}, bus.ack, 0);
        check_eq({tag, " ack_err"}, bus.ack_err, 0);
        check_eq({tag, " pipe_hold"}, bus.pipe_hold, 0);
        check_eq({tag, " exp_key_valid"}, bus.exp_key_valid, 0);
        check_eq({tag, " exp_key_in"}, bus.exp_key_in, 0);
        check_eq({tag, " key_owner"}, bus.key_owner, 0);
        check_eq({tag, " key_installed"}, bus.key_installed, 0);
    endtask

    initial begin
        int l0;
        bus.req            = '0;
        bus.req_key        = '0;
        bus.pipe_empty     = 1'b1;
        bus.exp_keys_valid = 1'b0;
        bus.exp_busy       = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_cyc[i] = 0;
            keep[i]    = 0;
        end

        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();

        // First key: full miss path
        raise(2, K0);
        push_ack(2, 1'b0, 1'b1, 2, 2 + EXP_LAT, -1);
        key_q.push_back(K0);
        wait_drain(200);

        // Same key from another requester: cache hit
        tick();
        l0 = load_cnt;
        raise(0, K0);
        push_ack(0, 1'b0, 1'b1, 2, 0, 2);
        wait_drain(50);
        check_eq("hit loads", load_cnt - l0, 0);

        // Round robin from rr_ptr 0, requester 0 stays asserted for one more round
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        hold_cnt = 0;
        l0 = load_cnt;
        keep[0] = 1;
        raise(0, K1);
        raise(1, K2);
        raise(3, K3);
        push_ack(0, 1'b0, 1'b1, 0, 2 + EXP_LAT, -1);
        push_ack(1, 1'b0, 1'b1, 1, 2 + EXP_LAT, -1);
        push_ack(3, 1'b0, 1'b1, 3, 2 + EXP_LAT, -1);
        push_ack(0, 1'b0, 1'b1, 0, 2 + EXP_LAT, -1);
        key_q.push_back(K1);
        key_q.push_back(K2);
        key_q.push_back(K3);
        key_q.push_back(K1);
        wait_drain(1000);
        check_eq("rr loads", load_cnt - l0, 4);
        check_eq("rr all served", bus.req, 0);

        // Pipeline not empty: stay in DRAIN with hold asserted
        tick();
        bus.pipe_empty = 1'b0;
        l0 = load_cnt;
        raise(1, K4);
        push_ack(1, 1'b0, 1'b1, 1, -1, -1);
        key_q.push_back(K4);
        tick();
        tick();
        for (int n = 0; n < 20; n++) begin
            tick();
            check_eq("drain hold", bus.pipe_hold, 1);
        end
        check_eq("drain loads", load_cnt - l0, 0);
        bus.pipe_empty = 1'b1;
        tick();
        check_eq("load after pipe_empty", bus.exp_key_valid, 1);
        wait_drain(200);

        // Expander never completes: timeout abort, then the same key misses again
        tick();
        exp_never = 1'b1;
        raise(2, K5);
        push_ack(2, 1'b1, 1'b0, 1, 1 + TIMEOUT, -1);
        key_q.push_back(K5);
        wait_drain(300);
        exp_never = 1'b0;
        tick();
        raise(2, K5);
        push_ack(2, 1'b0, 1'b1, 2, 2 + EXP_LAT, -1);
        key_q.push_back(K5);
        wait_drain(200);

        // Reset during WAIT abandons the transaction, the request is then served anew
        tick();
        l0 = load_cnt;
        raise(3, K6);
        key_q.push_back(K6);
        for (int n = 0; n < 20 && load_cnt == l0; n++) tick();
        check_eq("load before reset", load_cnt - l0, 1);
        repeat (5) tick();
        rst = 1'b1;
        sb_q.delete();
        key_q.delete();
        exp_cnt = 0;
        bus.exp_busy = 1'b0;
        bus.exp_keys_valid = 1'b0;
        tick();
        check_quiet("mid reset");
        rst = 1'b0;
        hold_cnt = 0;
        push_ack(3, 1'b0, 1'b1, 3, 2 + EXP_LAT, -1);
        key_q.push_back(K6);
        wait_drain(200);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
